// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths and FSM states.
// Optional feature macro used by the top level: REGFILE_ZERO_GUARD_EN.
package regfile_write_arbiter_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wr_slot.sv
// One-entry holding slot for a register write request (address + data + full flag).
module regfile_wr_slot
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // A load only happens when the slot is empty, so it never collides with a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between A and B, with a clear sweep.
// Define REGFILE_ZERO_GUARD_EN to suppress requester writes to the top register (XZR).
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

`ifdef REGFILE_ZERO_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    // rr == 0 means A wins the next two-way contest.
    state_t            state, state_d;
    logic              rr, rr_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              a_full, b_full, a_full_d, b_full_d;
    logic [ADDR_W-1:0] a_slot_addr, b_slot_addr;
    logic [DATA_W-1:0] a_slot_data, b_slot_data;
    logic              a_load, b_load, gnt_a, gnt_b;
    logic              a_ready_d, b_ready_d, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    function automatic logic guarded(input logic [ADDR_W-1:0] addr);
        return ZERO_GUARD && (addr == LAST_ADDR);
    endfunction

    assign a_load = a_valid && a_ready;
    assign b_load = b_valid && b_ready;

    regfile_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (a_load),
        .drain     (gnt_a),
        .load_addr (a_addr),
        .load_data (a_data),
        .full      (a_full),
        .addr      (a_slot_addr),
        .data      (a_slot_data)
    );

    regfile_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (b_load),
        .drain     (gnt_b),
        .load_addr (b_addr),
        .load_data (b_data),
        .full      (b_full),
        .addr      (b_slot_addr),
        .data      (b_slot_data)
    );

    // A clear request takes priority over any pending grant; slots simply wait it out.
    always_comb begin
        state_d   = state;
        rr_d      = rr;
        cnt_d     = cnt;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        unique case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    wr_en_d = 1'b1;
                    cnt_d   = ADDR_W'(1);
                end else begin
                    if (a_full && b_full) begin
                        gnt_a = !rr;
                        gnt_b = rr;
                        rr_d  = !rr;
                    end else if (a_full) begin
                        gnt_a = 1'b1;
                        rr_d  = 1'b1;
                    end else if (b_full) begin
                        gnt_b = 1'b1;
                        rr_d  = 1'b0;
                    end
                    if (gnt_a) begin
                        wr_en_d   = !guarded(a_slot_addr);
                        wr_addr_d = a_slot_addr;
                        wr_data_d = a_slot_data;
                    end else if (gnt_b) begin
                        wr_en_d   = !guarded(b_slot_addr);
                        wr_addr_d = b_slot_addr;
                        wr_data_d = b_slot_data;
                    end
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt;
                cnt_d     = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        a_full_d  = (a_full && !gnt_a) || a_load;
        b_full_d  = (b_full && !gnt_b) || b_load;
        a_ready_d = !a_full_d && (state_d == ST_IDLE);
        b_ready_d = !b_full_d && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr       <= 1'b0;
            cnt      <= '0;
            clr_busy <= 1'b0;
            a_ready  <= 1'b1;
            b_ready  <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_d;
            rr       <= rr_d;
            cnt      <= cnt_d;
            clr_busy <= (state_d == ST_CLEAR);
            a_ready  <= a_ready_d;
            b_ready  <= b_ready_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
        end
    end

endmodule
